// File: rtl/lcd_pkg.sv
// Shared command codes, FSM states and capture size for the LCD host sequencer.
package lcd_pkg;

  localparam int unsigned PIX_N = 64;

  typedef enum logic [2:0] {
    CMD_WRITE   = 3'd0,
    SHIFT_UP    = 3'd1,
    SHIFT_DOWN  = 3'd2,
    SHIFT_LEFT  = 3'd3,
    SHIFT_RIGHT = 3'd4,
    AVERAGE     = 3'd5,
    MIRROR_X    = 3'd6,
    MIRROR_Y    = 3'd7
  } cmd_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ISSUE,
    S_GAP,
    S_CAPTURE,
    S_FINISH
  } state_e;

endpackage

// File: rtl/lcd_host_seq_if.sv
// Command and IRB write-back signals between the host sequencer (master) and LCD controller (slave).
interface lcd_host_seq_if #(
  parameter int unsigned DATA_W = 8
);
  logic [2:0]        cmd;
  logic              cmd_valid;
  logic              busy;
  logic              IRB_RW;
  logic [5:0]        IRB_A;
  logic [DATA_W-1:0] IRB_D;
  logic              lcd_done;

  modport master (
    output cmd, cmd_valid,
    input  busy, IRB_RW, IRB_A, IRB_D, lcd_done
  );

  modport slave (
    input  cmd, cmd_valid,
    output busy, IRB_RW, IRB_A, IRB_D, lcd_done
  );
endinterface

// File: rtl/lcd_wb_capture.sv
// Write-back capture datapath: result buffer, checksum, byte count and address check.
// With LCD_HOST_TIMEOUT_EN defined, exposes a capture strobe for the watchdog.
module lcd_wb_capture #(
  parameter int unsigned PIX_N  = 64,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic              wr_n_i,
  input  logic [5:0]        addr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [5:0]        rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [13:0]       checksum_o,
  output logic [6:0]        wr_count_o,
  output logic              err_addr_o
`ifdef LCD_HOST_TIMEOUT_EN
  , output logic            fire_o
`endif
);

  localparam logic [6:0] PIX_L = 7'(PIX_N);

  logic [DATA_W-1:0] mem_q [64];
  logic [13:0]       checksum_q, checksum_d;
  logic [6:0]        wr_count_q, wr_count_d;
  logic              err_addr_q, err_addr_d;
  logic              fire;

  // Writes beyond a full count are dropped: the controller parks IRB_RW low at address 63.
  assign fire = en_i && !wr_n_i && (wr_count_q < PIX_L);

  always_comb begin
    checksum_d = checksum_q;
    wr_count_d = wr_count_q;
    err_addr_d = err_addr_q;
    if (clr_i) begin
      checksum_d = '0;
      wr_count_d = '0;
      err_addr_d = 1'b0;
    end else if (fire) begin
      checksum_d = checksum_q + 14'(data_i);
      wr_count_d = wr_count_q + 7'd1;
      if (addr_i != wr_count_q[5:0]) err_addr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      checksum_q <= '0;
      wr_count_q <= '0;
      err_addr_q <= 1'b0;
    end else begin
      checksum_q <= checksum_d;
      wr_count_q <= wr_count_d;
      err_addr_q <= err_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fire) mem_q[addr_i] <= data_i;
  end

  assign rd_data_o  = mem_q[rd_addr_i];
  assign checksum_o = checksum_q;
  assign wr_count_o = wr_count_q;
  assign err_addr_o = err_addr_q;
`ifdef LCD_HOST_TIMEOUT_EN
  assign fire_o     = fire;
`endif

endmodule

// File: rtl/lcd_host_seq.sv
// Host-side LCD command sequencer with IRB write-back capture.
// Optional LCD_HOST_TIMEOUT_EN adds a 12-bit watchdog and sticky timeout output.
module lcd_host_seq #(
  parameter int unsigned SCR_DEPTH = 16,
  parameter int unsigned SCR_AW    = 4,
  parameter int unsigned PIX_N     = lcd_pkg::PIX_N,
  parameter int unsigned DATA_W    = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              scr_we,
  input  logic [SCR_AW-1:0] scr_addr,
  input  logic [2:0]        scr_data,
  input  logic [SCR_AW:0]   scr_len,
  input  logic              start,
  lcd_host_seq_if.master    bus,
  input  logic [5:0]        rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              host_busy,
  output logic              host_done,
  output logic [13:0]       checksum,
  output logic [6:0]        wr_count,
  output logic              err_addr,
  output logic              early_wr
`ifdef LCD_HOST_TIMEOUT_EN
  , output logic            timeout
`endif
);

  import lcd_pkg::*;

  localparam logic [SCR_AW:0] DEPTH_L = (SCR_AW+1)'(SCR_DEPTH);
  localparam logic [6:0]      PIX_L   = 7'(PIX_N);

  state_e          state_q, state_d;
  logic [SCR_AW:0] ptr_q, ptr_d, len_q, len_d, ptr_nx;
  logic            host_busy_q, host_busy_d;
  logic            host_done_q, host_done_d;
  logic            early_wr_q, early_wr_d;
  logic [2:0]      scr_mem [SCR_DEPTH];
  logic [2:0]      issue_cmd;
  logic            clr, cap_en;

`ifdef LCD_HOST_TIMEOUT_EN
  logic [11:0]     wd_q;
  logic            timeout_q, timeout_d;
  logic            cap_fire;
`endif

  always_ff @(posedge clk) begin
    if (scr_we && state_q == S_IDLE) scr_mem[scr_addr] <= scr_data;
  end

  assign ptr_nx = ptr_q + (SCR_AW+1)'(1);
  assign cap_en = (state_q == S_CAPTURE);

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    len_d         = len_q;
    host_busy_d   = host_busy_q;
    host_done_d   = host_done_q;
    early_wr_d    = early_wr_q;
    clr           = 1'b0;
    bus.cmd       = '0;
    bus.cmd_valid = 1'b0;
    issue_cmd     = CMD_WRITE;
    if (ptr_q < len_q) issue_cmd = scr_mem[ptr_q[SCR_AW-1:0]];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d       = (scr_len > DEPTH_L) ? DEPTH_L : scr_len;
          ptr_d       = '0;
          host_busy_d = 1'b1;
          host_done_d = 1'b0;
          early_wr_d  = 1'b0;
          clr         = 1'b1;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!bus.busy) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        bus.cmd_valid = 1'b1;
        bus.cmd       = issue_cmd;
        if (ptr_q < len_q) ptr_d = ptr_nx;
        // A scripted write with entries still behind it ends the script early.
        if (issue_cmd == CMD_WRITE) begin
          if (ptr_q < len_q && ptr_nx < len_q) early_wr_d = 1'b1;
          state_d = S_CAPTURE;
        end else begin
          state_d = S_GAP;
        end
      end
      S_GAP:     state_d = S_WAIT;
      S_CAPTURE: begin
        if (bus.lcd_done && wr_count == PIX_L) state_d = S_FINISH;
      end
      S_FINISH: begin
        host_busy_d = 1'b0;
        host_done_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

`ifdef LCD_HOST_TIMEOUT_EN
    timeout_d = timeout_q;
    if (clr) timeout_d = 1'b0;
    if (wd_q == '1 && (state_q == S_WAIT || state_q == S_CAPTURE)) begin
      timeout_d = 1'b1;
      state_d   = S_FINISH;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      len_q       <= '0;
      host_busy_q <= 1'b0;
      host_done_q <= 1'b0;
      early_wr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      len_q       <= len_d;
      host_busy_q <= host_busy_d;
      host_done_q <= host_done_d;
      early_wr_q  <= early_wr_d;
    end
  end

`ifdef LCD_HOST_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
      if (state_d != state_q || cap_fire) wd_q <= '0;
      else if (wd_q != '1)                wd_q <= wd_q + 12'd1;
    end
  end

  assign timeout = timeout_q;
`endif

  lcd_wb_capture #(
    .PIX_N  (PIX_N),
    .DATA_W (DATA_W)
  ) u_capture (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr_i      (clr),
    .en_i       (cap_en),
    .wr_n_i     (bus.IRB_RW),
    .addr_i     (bus.IRB_A),
    .data_i     (bus.IRB_D),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (rd_data),
    .checksum_o (checksum),
    .wr_count_o (wr_count),
    .err_addr_o (err_addr)
`ifdef LCD_HOST_TIMEOUT_EN
    , .fire_o   (cap_fire)
`endif
  );

  assign host_busy = host_busy_q;
  assign host_done = host_done_q;
  assign early_wr  = early_wr_q;

endmodule

// File: tb/tb_lcd_host_seq.sv
// Directed bench for lcd_host_seq: script issue order, busy handshake, capture, error flags and reset.
module tb_lcd_host_seq;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       scr_we = 1'b0;
  logic [3:0] scr_addr = '0;
  logic [2:0] scr_data = '0;
  logic [4:0] scr_len = '0;
  logic       start = 1'b0;
  logic [5:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic       host_busy, host_done, err_addr, early_wr;
  logic [13:0] checksum;
  logic [6:0] wr_count;
`ifdef LCD_HOST_TIMEOUT_EN
  logic       timeout;
`endif

  always #5 clk = ~clk;

  lcd_host_seq_if #(.DATA_W(8)) bus ();

  lcd_host_seq #(
    .SCR_DEPTH (16),
    .SCR_AW    (4),
    .PIX_N     (64),
    .DATA_W    (8)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .scr_we    (scr_we),
    .scr_addr  (scr_addr),
    .scr_data  (scr_data),
    .scr_len   (scr_len),
    .start     (start),
    .bus       (bus.master),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .host_busy (host_busy),
    .host_done (host_done),
    .checksum  (checksum),
    .wr_count  (wr_count),
    .err_addr  (err_addr),
    .early_wr  (early_wr)
`ifdef LCD_HOST_TIMEOUT_EN
    , .timeout (timeout)
`endif
  );

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  // Strobe monitor: records issued commands and flags back-to-back or busy-time strobes.
  logic [2:0]  strobes[$];
  int unsigned viol = 0;
  logic        prev_v = 1'b0;
  logic        busy_smp = 1'b0;

  always @(posedge clk) busy_smp <= bus.busy;

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_v <= 1'b0;
    end else begin
      if (bus.cmd_valid) begin
        strobes.push_back(bus.cmd);
        if (prev_v || busy_smp) viol++;
      end
      prev_v <= bus.cmd_valid;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] a, input logic [2:0] d);
    scr_addr = a;
    scr_data = d;
    scr_we   = 1'b1;
    tick();
    scr_we   = 1'b0;
  endtask

  task automatic run_start(input logic [4:0] len);
    strobes.delete();
    scr_len = len;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic wait_write(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (bus.cmd_valid && bus.cmd == 3'd0) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, 32'(ok), 32'd1);
    tick();
  endtask

  task automatic wr_byte(input logic [5:0] a, input logic [7:0] d);
    bus.IRB_RW = 1'b0;
    bus.IRB_A  = a;
    bus.IRB_D  = d;
    tick();
  endtask

  task automatic finish_chk(input string tag, input logic [13:0] exp_sum);
    bus.IRB_RW   = 1'b0;
    bus.IRB_A    = 6'd63;
    bus.IRB_D    = 8'hFF;
    bus.lcd_done = 1'b1;
    tick();
    chk({tag, "_done_lat0"}, 32'(host_done), 32'd0);
    chk({tag, "_count"}, 32'(wr_count), 32'd64);
    bus.lcd_done = 1'b0;
    bus.IRB_RW   = 1'b1;
    tick();
    chk({tag, "_done_lat1"}, 32'(host_done), 32'd1);
    chk({tag, "_busy_clr"}, 32'(host_busy), 32'd0);
    chk({tag, "_sum"}, 32'(checksum), 32'(exp_sum));
  endtask

  initial begin
    int unsigned cnt;
    bus.busy = 1'b0; bus.IRB_RW = 1'b1; bus.IRB_A = '0; bus.IRB_D = '0; bus.lcd_done = 1'b0;

    // Reset values
    #2 reset_n = 1'b0;
    #2;
    chk("rst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
    chk("rst_cmd", 32'(bus.cmd), 32'd0);
    chk("rst_host_busy", 32'(host_busy), 32'd0);
    chk("rst_host_done", 32'(host_done), 32'd0);
    chk("rst_checksum", 32'(checksum), 32'd0);
    chk("rst_wr_count", 32'(wr_count), 32'd0);
    chk("rst_err_addr", 32'(err_addr), 32'd0);
    chk("rst_early_wr", 32'(early_wr), 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Empty script: implicit write only, bytes value=addr
    run_start(5'd0);
    chk("t1_host_busy", 32'(host_busy), 32'd1);
    wait_write("t1_strobe");
    for (int k = 0; k < 64; k++) wr_byte(6'(k), 8'(k));
    finish_chk("t1", 14'd2016);
    chk("t1_nstrobes", 32'(strobes.size()), 32'd1);
    if (strobes.size() == 1) chk("t1_cmd0", 32'(strobes[0]), 32'd0);
    rd_addr = 6'd0;  #1; chk("t1_buf0", 32'(rd_data), 32'd0);
    rd_addr = 6'd37; #1; chk("t1_buf37", 32'(rd_data), 32'd37);
    rd_addr = 6'd63; #1; chk("t1_buf63", 32'(rd_data), 32'd63);
    chk("t1_err_addr", 32'(err_addr), 32'd0);

    // Script [1,3,5]
    load(4'd0, 3'd1); load(4'd1, 3'd3); load(4'd2, 3'd5);
    run_start(5'd3);
    chk("t2_done_cleared", 32'(host_done), 32'd0);
    chk("t2_sum_cleared", 32'(checksum), 32'd0);
    wait_write("t2_strobe");
    for (int k = 0; k < 64; k++) wr_byte(6'(k), 8'(2 * k));
    finish_chk("t2", 14'd4032);
    chk("t2_nstrobes", 32'(strobes.size()), 32'd4);
    if (strobes.size() == 4) begin
      chk("t2_s0", 32'(strobes[0]), 32'd1);
      chk("t2_s1", 32'(strobes[1]), 32'd3);
      chk("t2_s2", 32'(strobes[2]), 32'd5);
      chk("t2_s3", 32'(strobes[3]), 32'd0);
    end
    chk("t2_early_wr", 32'(early_wr), 32'd0);

    // Busy held 100 cycles, then addresses 0,1,3,... with value 1
    bus.busy = 1'b1;
    run_start(5'd0);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.cmd_valid !== 1'b0) cnt++;
    end
    chk("t3_quiet_busy", cnt, 32'd0);
    bus.busy = 1'b0;
    tick();
    chk("t3_strobe_lat", 32'(bus.cmd_valid), 32'd1);
    chk("t3_strobe_cmd", 32'(bus.cmd), 32'd0);
    tick();
    for (int k = 0; k < 64; k++) wr_byte((k < 2) ? 6'(k) : 6'(k + 1), 8'd1);
    finish_chk("t4", 14'd64);
    chk("t4_err_addr", 32'(err_addr), 32'd1);
    rd_addr = 6'd3; #1; chk("t4_buf3", 32'(rd_data), 32'd1);
    rd_addr = 6'd2; #1; chk("t4_buf2_kept", 32'(rd_data), 32'd4);

    // Script [2,0,4]: write issued early, cmd 4 skipped
    load(4'd0, 3'd2); load(4'd1, 3'd0); load(4'd2, 3'd4);
    run_start(5'd3);
    chk("t5_err_cleared", 32'(err_addr), 32'd0);
    wait_write("t5_strobe");
    for (int k = 0; k < 64; k++) wr_byte(6'(k), 8'd3);
    finish_chk("t5", 14'd192);
    tick(); tick();
    chk("t5_early_wr", 32'(early_wr), 32'd1);
    chk("t5_nstrobes", 32'(strobes.size()), 32'd2);
    if (strobes.size() == 2) begin
      chk("t5_s0", 32'(strobes[0]), 32'd2);
      chk("t5_s1", 32'(strobes[1]), 32'd0);
    end

    // Reset mid-capture, then a fresh run
    run_start(5'd0);
    chk("t6_early_cleared", 32'(early_wr), 32'd0);
    wait_write("t6_strobe");
    for (int k = 0; k < 30; k++) wr_byte(6'(k), 8'd1);
    chk("t6_count30", 32'(wr_count), 32'd30);
    chk("t6_sum30", 32'(checksum), 32'd30);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_count", 32'(wr_count), 32'd0);
    chk("t6_rst_sum", 32'(checksum), 32'd0);
    chk("t6_rst_busy", 32'(host_busy), 32'd0);
    chk("t6_rst_done", 32'(host_done), 32'd0);
    chk("t6_rst_valid", 32'(bus.cmd_valid), 32'd0);
    bus.IRB_RW = 1'b1;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    chk("t6_idle_busy", 32'(host_busy), 32'd0);
    run_start(5'd0);
    wait_write("t6b_strobe");
    for (int k = 0; k < 64; k++) wr_byte(6'(k), 8'(k + 5));
    finish_chk("t6b", 14'd2336);
    chk("t6b_err_addr", 32'(err_addr), 32'd0);

    chk("strobe_rules", viol, 32'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
